int_div_seq_core: RTL and testbench

- Sequential radix-2 restoring unsigned integer divider core, one quotient bit per cycle.
- Sits directly downstream of the tt_um_damor_rbz pin wrapper.
- The wrapper captures operands from ui_in/uio_in and hands them over through a valid/ready pair.
- The core returns quotient, remainder and a divide-by-zero flag through a second valid/ready pair, which the wrapper drives onto uo_out/uio_out.

---
 rtl/int_div_pkg.sv | 17 +
 rtl/int_div_step.sv | 31 +++
 rtl/int_div_seq_core.sv | 174 +++++++++++++++++
 tb/tb_int_div_seq_core.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package int_div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Counter must hold WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/int_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it is non-negative.
module int_div_step
    import int_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    assign shifted = {a, q[WIDTH-1]};
    assign trial   = shifted - {2'b00, d};

    always_comb begin
        if (!trial[WIDTH+1]) begin
            a_next = trial[WIDTH:0];
            q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
            a_next = shifted[WIDTH:0];
            q_next = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/int_div_seq_core.sv
// Radix-2 restoring divider, one quotient bit per enabled cycle, with
// valid/ready on both sides. Define INT_DIV_SIGNED_EN for signed support.
module int_div_seq_core
    import int_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
`ifdef INT_DIV_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH:0]   a_reg, a_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             zero_reg, zero_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             dbz_reg, dbz_next;

    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    int_div_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_reg),
        .q      (q_reg),
        .d      (d_reg),
        .a_next (a_step),
        .q_next (q_step)
    );

`ifdef INT_DIV_SIGNED_EN
    logic q_neg_reg, q_neg_next;
    logic r_neg_reg, r_neg_next;

    // Magnitudes go through the unsigned datapath; signs are restored on write-back.
    assign dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign quo_fix = q_neg_reg ? -q_step : q_step;
    assign rem_fix = r_neg_reg ? -a_step[WIDTH-1:0] : a_step[WIDTH-1:0];

    always_comb begin
        q_neg_next = q_neg_reg;
        r_neg_next = r_neg_reg;
        if (state_reg == IDLE && ena && in_valid) begin
            q_neg_next = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_next = is_signed & dividend[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
        end else begin
            q_neg_reg <= q_neg_next;
            r_neg_reg <= r_neg_next;
        end
    end
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign quo_fix = q_step;
    assign rem_fix = a_step[WIDTH-1:0];
`endif

    always_comb begin
        state_next     = state_reg;
        a_next         = a_reg;
        q_next         = q_reg;
        d_next         = d_reg;
        cnt_next       = cnt_reg;
        zero_next      = zero_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
        case (state_reg)
            IDLE: begin
                if (ena && in_valid) begin
                    zero_next  = (divisor == '0);
                    a_next     = '0;
                    d_next     = dvs_mag;
                    state_next = CALC;
                    // A zero divisor spends one CALC cycle carrying the raw dividend in Q.
                    if (divisor == '0) begin
                        q_next   = dividend;
                        cnt_next = '0;
                    end else begin
                        q_next   = dvd_mag;
                        cnt_next = CNT_LOAD;
                    end
                end
            end
            CALC: begin
                if (ena) begin
                    a_next = a_step;
                    q_next = q_step;
                    if (cnt_reg == '0) begin
                        state_next = DONE;
                        if (zero_reg) begin
                            quotient_next  = '1;
                            remainder_next = q_reg;
                            dbz_next       = 1'b1;
                        end else begin
                            quotient_next  = quo_fix;
                            remainder_next = rem_fix;
                            dbz_next       = 1'b0;
                        end
                    end else begin
                        cnt_next = cnt_reg - CW'(1);
                    end
                end
            end
            DONE: begin
                if (ena && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            q_reg         <= '0;
            d_reg         <= '0;
            cnt_reg       <= '0;
            zero_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            q_reg         <= q_next;
            d_reg         <= d_next;
            cnt_reg       <= cnt_next;
            zero_reg      <= zero_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
        end
    end

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign busy        = (state_reg != IDLE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_int_div_seq_core.sv
// Directed bench for int_div_seq_core with a result scoreboard; covers the
// signed variant when INT_DIV_SIGNED_EN is defined.
module tb_int_div_seq_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       in_ready, out_valid, div_by_zero, busy;
    logic [7:0] quotient, remainder;
`ifdef INT_DIV_SIGNED_EN
    logic       is_signed = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } res_t;

    res_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;

    int_div_seq_core #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
`ifdef INT_DIV_SIGNED_EN
        .is_signed   (is_signed),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic sgn);
        res_t r;
        int   sa, sd, qi, ri;
        if (b == 8'd0) begin
            r.q = 8'hFF; r.r = a; r.dbz = 1'b1;
        end else if (sgn) begin
            sa = int'($signed(a));
            sd = int'($signed(b));
            qi = sa / sd;
            ri = sa % sd;
            r.q = qi[7:0]; r.r = ri[7:0]; r.dbz = 1'b0;
        end else begin
            r.q = a / b; r.r = a % b; r.dbz = 1'b0;
        end
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sgn);
        check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
`ifdef INT_DIV_SIGNED_EN
        is_signed = sgn;
`endif
        sbq.push_back(model(a, b, sgn));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag);
        res_t e;
        if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s_scoreboard: observed empty queue expected pending entry", tag);
        end else begin
            e = sbq.pop_front();
            check({tag, "_quotient"}, {24'd0, quotient}, {24'd0, e.q});
            check({tag, "_remainder"}, {24'd0, remainder}, {24'd0, e.r});
            check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
        end
    endtask

    task automatic wait_out(input int start, input int exp_lat, input string tag);
        int lat = start;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check_result(tag);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_out_valid_clear"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int k;
        int ov_seen;
        int got;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_quotient", {24'd0, quotient}, 32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal divide
        send(8'd100, 8'd7, 1'b0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_in_ready_low", {31'd0, in_ready}, 32'd0);
        wait_out(0, 8, "t1");
        $display("txn 100/7 -> q=%0d r=%0d dbz=%0d", quotient, remainder, div_by_zero);
        release_out("t1");

        // Divide-by-zero, then a normal divide clears the flag
        send(8'd5, 8'd0, 1'b0);
        wait_out(0, 1, "t2_dbz");
        $display("txn 5/0 -> q=%0d r=%0d dbz=%0d", quotient, remainder, div_by_zero);
        release_out("t2_dbz");
        send(8'd255, 8'd1, 1'b0);
        wait_out(0, 8, "t2_255_1");
        $display("txn 255/1 -> q=%0d r=%0d dbz=%0d", quotient, remainder, div_by_zero);
        release_out("t2_255_1");

        // Backpressure: result held, new operands ignored
        send(8'd200, 8'd13, 1'b0);
        wait_out(0, 8, "t3");
        dividend = 8'd1;
        divisor  = 8'd1;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t3_hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("t3_hold_quotient", {24'd0, quotient}, 32'd15);
            check("t3_hold_remainder", {24'd0, remainder}, 32'd5);
            check("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        ena = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_ena_low_no_handshake", {31'd0, out_valid}, 32'd1);
        ena = 1'b1;
        in_valid = 1'b0;
        $display("txn 200/13 -> q=%0d r=%0d (held under backpressure)", quotient, remainder);
        release_out("t3");

        // ena stall mid-CALC stretches latency by 3
        send(8'd100, 8'd7, 1'b0);
        repeat (2) @(negedge clk);
        ena = 1'b0;
        repeat (3) @(negedge clk);
        ena = 1'b1;
        wait_out(5, 11, "t4_stall");
        $display("txn 100/7 stalled -> q=%0d r=%0d", quotient, remainder);
        release_out("t4_stall");

        // Reset mid-CALC aborts with no result
        send(8'd77, 8'd5, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(sbq.pop_back());
        check("t4_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("t4_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("t4_rst_busy", {31'd0, busy}, 32'd0);
        check("t4_rst_quotient", {24'd0, quotient}, 32'd0);
        ov_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1;
        end
        check("t4_rst_no_result", ov_seen, 32'd0);
        $display("txn 77/5 aborted by reset");

        // Back-to-back with out_ready tied high
        out_ready = 1'b1;
        check("t5_in_ready_first", {31'd0, in_ready}, 32'd1);
        dividend = 8'd9;
        divisor  = 8'd3;
        in_valid = 1'b1;
        sbq.push_back(model(8'd9, 8'd3, 1'b0));
        @(posedge clk);
        @(negedge clk);
        dividend = 8'd0;
        divisor  = 8'd9;
        sbq.push_back(model(8'd0, 8'd9, 1'b0));
        k = 0;
        got = 0;
        while (!in_ready && k < 64) begin
            if (out_valid && got == 0) begin
                check("t5a_latency", k, 32'd8);
                check_result("t5a");
                $display("txn 9/3 -> q=%0d r=%0d", quotient, remainder);
                got = 1;
            end
            @(negedge clk);
            k++;
        end
        check("t5a_seen", got, 32'd1);
        check("t5_second_accept_gap", k + 1, 32'd10);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(0, 8, "t5b");
        $display("txn 0/9 -> q=%0d r=%0d", quotient, remainder);
        @(negedge clk);
        check("t5b_auto_release", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

`ifdef INT_DIV_SIGNED_EN
        // Signed divides
        send(8'h9C, 8'd7, 1'b1);
        wait_out(0, 8, "t6_m100_7");
        $display("txn -100/7 -> q=0x%0h r=0x%0h", quotient, remainder);
        release_out("t6_m100_7");
        send(8'h80, 8'hFF, 1'b1);
        wait_out(0, 8, "t6_m128_m1");
        $display("txn -128/-1 -> q=0x%0h r=0x%0h", quotient, remainder);
        release_out("t6_m128_m1");
        send(8'd100, 8'hF9, 1'b1);
        wait_out(0, 8, "t6_100_m7");
        $display("txn 100/-7 -> q=0x%0h r=0x%0h", quotient, remainder);
        release_out("t6_100_m7");
`endif

        check("sb_empty", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
